// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg -- shared types for the clock-setting controller.
//   state_t          : RUN / SET_H / SET_M / SET_S controller states
//   FIELD_*          : field_sel encodings that drive the display blink
//   BTN_INC/BTN_DEC  : lane indices of the adjust-button pulse generators
//   cnt_width()      : counter width for a modulus, never below 1 bit
// Optional feature macro used by the importers: CLOCK_SET_AUTO_REPEAT_EN.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        SET_H = 2'b01,
        SET_M = 2'b10,
        SET_S = 2'b11
    } state_t;

    localparam logic [1:0] FIELD_NONE = 2'b00;
    localparam logic [1:0] FIELD_H    = 2'b01;
    localparam logic [1:0] FIELD_M    = 2'b10;
    localparam logic [1:0] FIELD_S    = 2'b11;

    localparam int BTN_INC     = 0;
    localparam int BTN_DEC     = 1;
    localparam int NUM_ADJ_BTN = 2;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_pulse.sv
// btn_pulse -- rising-edge press detector with optional auto-repeat.
// Macro: CLOCK_SET_AUTO_REPEAT_EN adds the hold counter, the REPEAT_DLY /
// REPEAT_PER parameters and the clr port; without it only edge detect exists.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : (auto-repeat build only) clears the hold counter
//   btn        : debounced active-high button level
//   fire       : combinational request, high for one cycle per press/repeat;
//                the parent registers it
module btn_pulse
    import clock_ctrl_pkg::*;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
#(
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10
)
`endif
(
    input  logic clk,
    input  logic rst_n,
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    input  logic clr,
`endif
    input  logic btn,
    output logic fire
);

    logic prev;
    logic press;

    assign press = btn & ~prev;

    always_ff @(posedge clk) begin
        if (!rst_n) prev <= 1'b0;
        else        prev <= btn;
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int RW = cnt_width((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);
    localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PER - 1);

    logic [RW-1:0] hold_cnt;
    logic          rpt;      // 0: waiting out the initial delay, 1: periodic
    logic          rpt_hit;

    // hold_cnt counts cycles held since the press (or last repeat), so the
    // first repeat lands REPEAT_DLY cycles after the press pulse.
    assign rpt_hit = btn & prev & ~clr & (hold_cnt == (rpt ? PER_MAX : DLY_MAX));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            rpt      <= 1'b0;
        end else if (!btn || clr || press) begin
            hold_cnt <= '0;
            rpt      <= 1'b0;
        end else if (rpt_hit) begin
            hold_cnt <= '0;
            rpt      <= 1'b1;
        end else begin
            hold_cnt <= hold_cnt + RW'(1);
        end
    end

    assign fire = press | rpt_hit;
`else
    assign fire = press;
`endif

endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl -- run/set controller for a digital clock.
// Macro: CLOCK_SET_AUTO_REPEAT_EN enables auto-repeat on held inc/dec.
// Parameters: TICK_DIV (cycles per en_s), REPEAT_DLY, REPEAT_PER, TIMEOUT.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   btn_mode, btn_inc, btn_dec : debounced active-high button levels
//   en_s                       : one-cycle seconds-advance pulse (RUN only)
//   up_*/down_*                : one-cycle adjust pulses for h/m/s
//   field_sel                  : 00 none, 01 h, 10 m, 11 s (blink select)
//   setting                    : high in any SET state
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 100,
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10,
    parameter int TIMEOUT    = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    output logic       en_s,
    output logic       up_s,
    output logic       down_s,
    output logic       up_m,
    output logic       down_m,
    output logic       up_h,
    output logic       down_h,
    output logic [1:0] field_sel,
    output logic       setting
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam int IW = cnt_width(TIMEOUT);
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

    // Out-of-range configurations elaborate this empty marker block; it is
    // the only place the repeat parameters appear in the default build.
    if (TICK_DIV < 2 || TIMEOUT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cfg
    end

    state_t                  state, state_nxt;
    logic                    mode_prev;
    logic                    press_mode;
    logic [NUM_ADJ_BTN-1:0]  adj_btn;
    logic [NUM_ADJ_BTN-1:0]  adj_fire;
    logic                    both;
    logic                    any_btn;
    logic                    adj_ok;
    logic                    timeout;
    logic [PW-1:0]           presc, presc_nxt;
    logic [IW-1:0]           idle, idle_nxt;
    logic [2:0]              fld_oh;   // {h, m, s}
    logic [2:0]              up_nxt, dn_nxt;
    logic                    en_nxt;

    assign press_mode = btn_mode & ~mode_prev;
    assign adj_btn    = {btn_dec, btn_inc};
    assign both       = btn_inc & btn_dec;
    assign any_btn    = btn_mode | btn_inc | btn_dec;

    for (genvar g = 0; g < NUM_ADJ_BTN; g++) begin : g_adj
        btn_pulse
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        #(
            .REPEAT_DLY (REPEAT_DLY),
            .REPEAT_PER (REPEAT_PER)
        )
`endif
        u_btn (
            .clk   (clk),
            .rst_n (rst_n),
`ifdef CLOCK_SET_AUTO_REPEAT_EN
            .clr   (both),
`endif
            .btn   (adj_btn[g]),
            .fire  (adj_fire[g])
        );
    end

    assign timeout = (state != RUN) && !any_btn && (idle == IDLE_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (press_mode) state_nxt = SET_H;
            SET_H:   if (press_mode) state_nxt = SET_M; else if (timeout) state_nxt = RUN;
            SET_M:   if (press_mode) state_nxt = SET_S; else if (timeout) state_nxt = RUN;
            SET_S:   if (press_mode || timeout) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Prescaler advances only while staying in RUN, is frozen in SET states,
    // and restarts from zero on every return to RUN.
    always_comb begin
        presc_nxt = presc;
        if (state_nxt == RUN) begin
            if (state != RUN || presc == TICK_MAX) presc_nxt = '0;
            else                                   presc_nxt = presc + PW'(1);
        end
    end

    always_comb begin
        idle_nxt = idle + IW'(1);
        if (state_nxt == RUN || any_btn) idle_nxt = '0;
    end

    // Adjust pulses only come from SET states and en_s only from RUN, so the
    // two can never coincide; the mode-entry edge also suppresses en_s so it
    // never shows alongside setting=1.
    assign fld_oh = {state == SET_H, state == SET_M, state == SET_S};
    assign adj_ok = (state != RUN) && !press_mode && !both;
    assign up_nxt = fld_oh & {3{adj_ok & adj_fire[BTN_INC]}};
    assign dn_nxt = fld_oh & {3{adj_ok & adj_fire[BTN_DEC]}};
    assign en_nxt = (state == RUN) && (state_nxt == RUN) && (presc == TICK_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            mode_prev <= 1'b0;
            presc     <= '0;
            idle      <= '0;
            en_s      <= 1'b0;
            {up_h, up_m, up_s}       <= 3'b000;
            {down_h, down_m, down_s} <= 3'b000;
        end else begin
            state     <= state_nxt;
            mode_prev <= btn_mode;
            presc     <= presc_nxt;
            idle      <= idle_nxt;
            en_s      <= en_nxt;
            {up_h, up_m, up_s}       <= up_nxt;
            {down_h, down_m, down_s} <= dn_nxt;
        end
    end

    always_comb begin
        field_sel = FIELD_NONE;
        case (state)
            SET_H:   field_sel = FIELD_H;
            SET_M:   field_sel = FIELD_M;
            SET_S:   field_sel = FIELD_S;
            default: field_sel = FIELD_NONE;
        endcase
    end

    assign setting = (state != RUN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl -- self-checking bench for clock_set_ctrl (default params).
// Expected output words are queued when a cycle's stimulus is driven and
// popped/compared on the following falling edge. Honors
// CLOCK_SET_AUTO_REPEAT_EN for the held-button expectations.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, btn_mode, btn_inc, btn_dec;
    logic       en_s, up_s, down_s, up_m, down_m, up_h, down_h, setting;
    logic [1:0] field_sel;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .TICK_DIV   (100),
        .REPEAT_DLY (50),
        .REPEAT_PER (10),
        .TIMEOUT    (1000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .en_s      (en_s),
        .up_s      (up_s),
        .down_s    (down_s),
        .up_m      (up_m),
        .down_m    (down_m),
        .up_h      (up_h),
        .down_h    (down_h),
        .field_sel (field_sel),
        .setting   (setting)
    );

    // pulse masks, order {en_s, up_h, down_h, up_m, down_m, up_s, down_s}
    localparam logic [6:0] NO = 7'b0000000;
    localparam logic [6:0] EN = 7'b1000000;
    localparam logic [6:0] UH = 7'b0100000;
    localparam logic [6:0] DH = 7'b0010000;
    localparam logic [6:0] UM = 7'b0001000;
    localparam logic [6:0] DM = 7'b0000100;
    localparam logic [6:0] US = 7'b0000010;
    localparam logic [6:0] DS = 7'b0000001;
    localparam logic [1:0] FN = 2'b00, FH = 2'b01, FM = 2'b10, FS = 2'b11;

    typedef struct packed {
        logic       m;
        logic       i;
        logic       d;
        logic [6:0] pulses;
        logic [1:0] fld;
    } vec_t;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [9:0]  exp_q[$];
    string       name_q[$];
    vec_t        tbl[31];

    function automatic logic [9:0] ev(input logic [6:0] p, input logic [1:0] f);
        return {p, (f != 2'b00), f};
    endfunction

    task automatic cyc(input logic r, input logic m, input logic i, input logic d,
                       input logic [9:0] e, input string nm);
        logic [9:0] act, want;
        string      n;
        rst_n = r; btn_mode = m; btn_inc = i; btn_dec = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        act  = {en_s, up_h, down_h, up_m, down_m, up_s, down_s, setting, field_sel};
        want = exp_q.pop_front();
        n    = name_q.pop_front();
        n_run++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", n, act, want);
        end
    endtask

    // n idle cycles; en_s expected at first_en and every 100 after (0 = never)
    task automatic idle(input int n, input int first_en, input logic [1:0] f, input string nm);
        for (int j = 1; j <= n; j++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0,
                ev((first_en > 0 && j >= first_en && (j - first_en) % 100 == 0) ? EN : NO, f), nm);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic rpt_en;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        rpt_en = 1'b1;
`else
        rpt_en = 1'b0;
`endif
        //             m     i     d     pulses fld
        tbl[0]  = '{1'b1, 1'b0, 1'b0, NO, FH};  // RUN -> SET_H
        tbl[1]  = '{1'b0, 1'b0, 1'b0, NO, FH};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, UH, FH};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, NO, FH};  // held: no second pulse
        tbl[4]  = '{1'b0, 1'b0, 1'b0, NO, FH};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, DH, FH};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, NO, FH};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, NO, FM};  // SET_H -> SET_M
        tbl[8]  = '{1'b0, 1'b0, 1'b0, NO, FM};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, UM, FM};
        tbl[10] = '{1'b0, 1'b1, 1'b0, NO, FM};
        tbl[11] = '{1'b0, 1'b1, 1'b0, NO, FM};
        tbl[12] = '{1'b0, 1'b0, 1'b0, NO, FM};
        tbl[13] = '{1'b0, 1'b0, 1'b1, DM, FM};
        tbl[14] = '{1'b0, 1'b0, 1'b0, NO, FM};
        tbl[15] = '{1'b0, 1'b1, 1'b1, NO, FM};  // inc+dec together
        tbl[16] = '{1'b0, 1'b0, 1'b0, NO, FM};
        tbl[17] = '{1'b0, 1'b0, 1'b1, DM, FM};
        tbl[18] = '{1'b0, 1'b1, 1'b1, NO, FM};  // inc rises while dec held
        tbl[19] = '{1'b0, 1'b0, 1'b0, NO, FM};
        tbl[20] = '{1'b1, 1'b1, 1'b0, NO, FS};  // mode wins over inc
        tbl[21] = '{1'b0, 1'b0, 1'b0, NO, FS};
        tbl[22] = '{1'b0, 1'b1, 1'b0, US, FS};
        tbl[23] = '{1'b0, 1'b0, 1'b0, NO, FS};
        tbl[24] = '{1'b0, 1'b0, 1'b1, DS, FS};
        tbl[25] = '{1'b0, 1'b0, 1'b0, NO, FS};
        tbl[26] = '{1'b1, 1'b0, 1'b0, NO, FN};  // SET_S -> RUN
        tbl[27] = '{1'b0, 1'b0, 1'b0, NO, FN};
        tbl[28] = '{1'b0, 1'b1, 1'b0, NO, FN};  // inc ignored in RUN
        tbl[29] = '{1'b0, 1'b0, 1'b1, NO, FN};  // dec ignored in RUN
        tbl[30] = '{1'b0, 1'b0, 1'b0, NO, FN};

        rst_n = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
        @(negedge clk);

        // reset holds everything at zero even with buttons active
        cyc(1'b0, 1'b1, 1'b1, 1'b0, ev(NO, FN), "reset_a");
        cyc(1'b0, 1'b0, 1'b0, 1'b1, ev(NO, FN), "reset_b");
        cyc(1'b0, 1'b0, 1'b0, 1'b0, ev(NO, FN), "reset_c");

        // free-running prescaler: en_s at 100, 200, 300 after release
        idle(300, 100, FN, "run_tick");

        // table-driven mode/adjust vectors
        for (int k = 0; k < 31; k++)
            cyc(1'b1, tbl[k].m, tbl[k].i, tbl[k].d, ev(tbl[k].pulses, tbl[k].fld),
                $sformatf("vec%0d", k));

        // prescaler restarted at the SET_S->RUN edge (tbl[26]), 4 cycles ago
        idle(96, 96, FN, "run_restart");

        // walk to SET_S then idle out
        cyc(1'b1, 1'b1, 1'b0, 1'b0, ev(NO, FH), "to_h");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ev(NO, FH), "to_h_rel");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, ev(NO, FM), "to_m");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ev(NO, FM), "to_m_rel");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, ev(NO, FS), "to_s");
        idle(999, 0, FS, "set_s_idle");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ev(NO, FN), "timeout");
        idle(100, 100, FN, "post_timeout");

        // held inc in SET_H
        cyc(1'b1, 1'b1, 1'b0, 1'b0, ev(NO, FH), "hold_enter");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ev(NO, FH), "hold_enter_rel");
        for (int j = 1; j <= 80; j++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0,
                ev((j == 1 || (rpt_en && (j == 51 || j == 61 || j == 71))) ? UH : NO, FH),
                $sformatf("hold_%0d", j));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ev(NO, FH), "hold_rel");

        // reset during a hold in SET_H
        cyc(1'b1, 1'b0, 1'b1, 1'b0, ev(UH, FH), "rst_hold_press");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, ev(NO, FH), "rst_hold_a");
        cyc(1'b0, 1'b0, 1'b1, 1'b0, ev(NO, FN), "rst_mid_hold");
        for (int j = 1; j <= 60; j++)
            cyc(1'b1, 1'b0, 1'b1, 1'b0, ev(NO, FN), $sformatf("after_rst_%0d", j));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, ev(NO, FN), "after_rst_rel");

        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
